// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Recovers BCD digits from a multiplexed, active-high 7-segment display bus.
// Each {seg, dig_en} sample must be one-hot on dig_en and must repeat for
// STABLE_CNT consecutive clock edges before it is accepted. Once accepted, the
// pattern is decoded back to BCD and committed into that digit's slot.
//
// Parameters
//   DIGITS      number of scanned digit positions (1..8)
//   STABLE_CNT  consecutive identical samples required for a commit (2..255)
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   seg      segment lines, bit0=a .. bit6=g, active-high
//   dig_en   digit select, must be one-hot to count as a sample
//   bcd_out  decoded digits, digit i in [4i+3:4i]; 4'hF when not a digit
//   valid    digit i holds a legal value 0..9
//   blank    digit i last committed an all-off pattern
//   update   one-cycle pulse after every commit
//   err      one-cycle pulse after a commit of an illegal pattern
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// seg7_digit_slot
//
// Holds the committed state of one digit position. It loads only when the
// top-level commit selects this position.
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   we_i       load strobe for this position
//   bcd_i      decoded value to store (4'hF for blank or illegal)
//   valid_i    stored pattern was a legal digit
//   blank_i    stored pattern was all segments off
//   bcd_o      stored value
//   valid_o    stored valid flag
//   blank_o    stored blank flag
// -----------------------------------------------------------------------------
module seg7_digit_slot (
   input  logic       clk,
   input  logic       rst,
   input  logic       we_i,
   input  logic [3:0] bcd_i,
   input  logic       valid_i,
   input  logic       blank_i,
   output logic [3:0] bcd_o,
   output logic       valid_o,
   output logic       blank_o
);

   logic [3:0] bcd_q;
   logic       valid_q;
   logic       blank_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q   <= 4'hF;
         valid_q <= 1'b0;
         blank_q <= 1'b0;
      end else if (we_i) begin
         bcd_q   <= bcd_i;
         valid_q <= valid_i;
         blank_q <= blank_i;
      end
   end

   assign bcd_o   = bcd_q;
   assign valid_o = valid_q;
   assign blank_o = blank_q;

endmodule

module seg7_scan_decoder #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CNT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     dig_en,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     valid,
   output logic [DIGITS-1:0]     blank,
   output logic                  update,
   output logic                  err
);

   localparam int              CW      = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CNT);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);

   // ---------------------------------------------------------------------------
   // Sample register and run counter
   // ---------------------------------------------------------------------------
   logic [6:0]        seg_q;
   logic [DIGITS-1:0] en_q;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic one_hot;
   logic same;
   logic commit;

   assign one_hot = $onehot(dig_en);
   assign same    = (seg == seg_q) && (dig_en == en_q);

   // cnt_q == 0 means "no run in progress", so a sample that happens to match
   // the held register right after reset or a non-one-hot gap still starts a
   // fresh run at 1 instead of continuing a discarded one.
   always_comb begin
      cnt_d = '0;
      if (!one_hot) begin
         cnt_d = '0;
      end else if (same && (cnt_q != '0)) begin
         cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
      end else begin
         cnt_d = CNT_ONE;
      end
   end

   // Commit only on the edge that reaches CNT_MAX; a saturated run stays put
   // and therefore cannot commit twice.
   assign commit = one_hot && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= '0;
         en_q  <= '0;
         cnt_q <= '0;
      end else begin
         seg_q <= seg;
         en_q  <= dig_en;
         cnt_q <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Pattern decode (inverse of the BCD-to-7-segment encoder)
   // ---------------------------------------------------------------------------
   logic [3:0] dec_val;
   logic       dec_legal;
   logic       dec_blank;
   logic       dec_err;

   always_comb begin
      dec_val   = 4'hF;
      dec_legal = 1'b1;
      case (seg)
         7'b0111111: dec_val = 4'd0;
         7'b0000110: dec_val = 4'd1;
         7'b1011011: dec_val = 4'd2;
         7'b1001111: dec_val = 4'd3;
         7'b1100110: dec_val = 4'd4;
         7'b1101101: dec_val = 4'd5;
         7'b1111101: dec_val = 4'd6;
         7'b0000111: dec_val = 4'd7;
         7'b1111111: dec_val = 4'd8;
         7'b1101111: dec_val = 4'd9;
         default: begin
            dec_val   = 4'hF;
            dec_legal = 1'b0;
         end
      endcase
   end

   assign dec_blank = (seg == 7'b0000000);
   assign dec_err   = !dec_legal && !dec_blank;

   // ---------------------------------------------------------------------------
   // Per-digit slots; the one-hot select doubles as the write-enable vector
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < DIGITS; g++) begin : g_slot
      seg7_digit_slot u_slot (
         .clk     (clk),
         .rst     (rst),
         .we_i    (commit && dig_en[g]),
         .bcd_i   (dec_val),
         .valid_i (dec_legal),
         .blank_i (dec_blank),
         .bcd_o   (bcd_out[4*g +: 4]),
         .valid_o (valid[g]),
         .blank_o (blank[g])
      );
   end

   // ---------------------------------------------------------------------------
   // Event pulses
   // ---------------------------------------------------------------------------
   logic update_q, update_d;
   logic err_q, err_d;

   assign update_d = commit;
   assign err_d    = commit && dec_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         update_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         update_q <= update_d;
         err_q    <= err_d;
      end
   end

   assign update = update_q;
   assign err    = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed-vector bench for seg7_scan_decoder (DIGITS=4, STABLE_CNT=4).
// The driver pushes the hand-computed post-commit state and commit cycle into
// a scoreboard queue; a monitor pops one entry per update pulse and compares.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

   localparam int DIGITS = 4;
   localparam int STB    = 4;

   localparam logic [6:0] P0 = 7'b0111111;
   localparam logic [6:0] P1 = 7'b0000110;
   localparam logic [6:0] P2 = 7'b1011011;
   localparam logic [6:0] P3 = 7'b1001111;
   localparam logic [6:0] P9 = 7'b1101111;

   logic              clk;
   logic              rst;
   logic [6:0]        seg;
   logic [DIGITS-1:0] dig_en;
   logic [15:0]       bcd_out;
   logic [3:0]        valid;
   logic [3:0]        blank;
   logic              update;
   logic              err;

   seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(STB)) dut (
      .clk     (clk),
      .rst     (rst),
      .seg     (seg),
      .dig_en  (dig_en),
      .bcd_out (bcd_out),
      .valid   (valid),
      .blank   (blank),
      .update  (update),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] bcd;
      logic [3:0]  v;
      logic [3:0]  b;
      logic        e;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_tot  = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Hold one sample for n edges; when a commit is expected, record the state
   // the DUT should show and the edge at which it must appear.
   task automatic run(input logic [6:0] s, input logic [3:0] en, input int n,
                      input bit cm, input logic [15:0] b, input logic [3:0] v,
                      input logic [3:0] bl, input logic e);
      exp_t x;
      seg    = s;
      dig_en = en;
      if (cm) begin
         x.bcd = b; x.v = v; x.b = bl; x.e = e; x.cyc = cyc + STB;
         sb.push_back(x);
      end
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_bcd"},    {16'h0, bcd_out}, 32'h0000FFFF);
      chk({tag, "_valid"},  {28'h0, valid},   32'h0);
      chk({tag, "_blank"},  {28'h0, blank},   32'h0);
      chk({tag, "_update"}, {31'h0, update},  32'h0);
      chk({tag, "_err"},    {31'h0, err},     32'h0);
   endtask

   // Monitor: every update pulse must match the next scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (update === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("spurious_update", {31'h0, update}, 32'h0);
               end else begin
                  e = sb.pop_front();
                  chk("commit_bcd",   {16'h0, bcd_out}, {16'h0, e.bcd});
                  chk("commit_valid", {28'h0, valid},   {28'h0, e.v});
                  chk("commit_blank", {28'h0, blank},   {28'h0, e.b});
                  chk("commit_err",   {31'h0, err},     {31'h0, e.e});
                  chk("commit_cycle", cyc,              e.cyc);
               end
            end else begin
               chk("err_idle", {31'h0, err}, 32'h0);
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      seg    = '0;
      dig_en = '0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         seg    = 7'($urandom);
         dig_en = 4'($urandom);
         @(negedge clk);
      end
      chk_reset("reset");
      rst    = 1'b0;
      mon_en = 1'b1;

      // Single digit: one commit, then a long hold gives nothing more.
      run(P0, 4'b0001, 4,  1, 16'hFFF0, 4'b0001, 4'b0000, 1'b0);
      run(P0, 4'b0001, 10, 0, '0, '0, '0, 1'b0);

      // Glitch: three samples only.
      run(P3, 4'b0010, 3, 0, '0, '0, '0, 1'b0);
      chk("glitch_d1_bcd",   {28'h0, bcd_out[7:4]}, 32'hF);
      chk("glitch_d1_valid", {31'h0, valid[1]},     32'h0);

      // Full scan, two rounds of 1,2,3,9.
      run(P1, 4'b0001, 8, 1, 16'hFFF1, 4'b0001, 4'b0000, 1'b0);
      run(P2, 4'b0010, 8, 1, 16'hFF21, 4'b0011, 4'b0000, 1'b0);
      run(P3, 4'b0100, 8, 1, 16'hF321, 4'b0111, 4'b0000, 1'b0);
      run(P9, 4'b1000, 8, 1, 16'h9321, 4'b1111, 4'b0000, 1'b0);
      run(P1, 4'b0001, 8, 1, 16'h9321, 4'b1111, 4'b0000, 1'b0);
      run(P2, 4'b0010, 8, 1, 16'h9321, 4'b1111, 4'b0000, 1'b0);
      run(P3, 4'b0100, 8, 1, 16'h9321, 4'b1111, 4'b0000, 1'b0);
      run(P9, 4'b1000, 8, 1, 16'h9321, 4'b1111, 4'b0000, 1'b0);
      chk("scan_bcd",   {16'h0, bcd_out}, 32'h9321);
      chk("scan_valid", {28'h0, valid},   32'hF);

      // Illegal pattern, then blank, on digit 2.
      run(7'b0000001, 4'b0100, 4, 1, 16'h9F21, 4'b1011, 4'b0000, 1'b1);
      run(7'b0000000, 4'b0100, 4, 1, 16'h9F21, 4'b1011, 4'b0100, 1'b0);
      chk("blank_d2", {31'h0, blank[2]}, 32'h1);

      // Non-one-hot select never commits.
      run(P0, 4'b0011, 20, 0, '0, '0, '0, 1'b0);
      chk("nonhot_bcd", {16'h0, bcd_out}, 32'h9F21);

      // Reset in the middle of a run; a full fresh run is needed afterwards.
      run(P0, 4'b0001, 2, 0, '0, '0, '0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_reset("midrun_reset");
      rst = 1'b0;
      run(P0, 4'b0001, 4, 1, 16'hFFF0, 4'b0001, 4'b0000, 1'b0);

      run(P0, 4'b0000, 6, 0, '0, '0, '0, 1'b0);
      chk("sb_drained", sb.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
